// File: rtl/iq_sample_deserializer.sv
// iq_sample_deserializer: pairs alternating I/Q samples into 32-bit words buffered in an FWFT FIFO
module iq_sample_deserializer #(
  parameter int ADDR_W  = 9,
  parameter bit SWAP_IQ = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       in_data,
  input  logic              in_valid,
  input  logic              in_sync,
  input  logic              rd_en,
  output logic [31:0]       rd_data,
  output logic              rd_dr,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              misalign,
  output logic [15:0]       drop_count,
  input  logic              clr_status
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {WAIT_I, WAIT_Q} state_t;
  state_t            r_state, w_state_nxt;
  logic [15:0]       r_i;
  logic [ADDR_W-1:0] r_wptr, r_rptr, w_rptr_nxt;
  logic [ADDR_W:0]   r_level, w_level_nxt;
  logic [31:0]       r_mem [DEPTH];
  logic [31:0]       r_rd_data, w_pair;
  logic              r_rd_dr, r_overflow, r_misalign;
  logic [15:0]       r_drop_count;
  logic              w_wr_req, w_misalign_evt, w_full, w_pop, w_wr, w_drop, w_bypass;
  // pairing decisions and FIFO bookkeeping; the bypass covers a write landing on the address being fetched
  always_comb begin
    w_state_nxt    = r_state;
    w_wr_req       = 1'b0;
    w_misalign_evt = 1'b0;
    w_state_nxt    = in_valid ? (in_sync ? WAIT_Q : WAIT_I) : r_state;
    w_wr_req       = in_valid & ~in_sync & (r_state == WAIT_Q);
    w_misalign_evt = in_valid & (in_sync == (r_state == WAIT_Q));
  end
  assign w_pair      = SWAP_IQ ? {in_data, r_i} : {r_i, in_data};
  assign w_full      = (r_level == (ADDR_W+1)'(DEPTH));
  assign w_pop       = rd_en & r_rd_dr;
  assign w_wr        = w_wr_req & (~w_full | w_pop);
  assign w_drop      = w_wr_req & w_full & ~w_pop;
  assign w_rptr_nxt  = r_rptr + ADDR_W'(w_pop);
  assign w_level_nxt = r_level + (ADDR_W+1)'(w_wr) - (ADDR_W+1)'(w_pop);
  assign w_bypass    = w_wr & (r_wptr == w_rptr_nxt);
  // pairing state and held I word
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= WAIT_I;
      r_i     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (in_valid && in_sync) r_i <= in_data;
    end
  end
  // block RAM write port, no reset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= w_pair;
  end
  // pointers, level and the registered head word fetched at the next read pointer
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_rd_dr   <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_wptr  <= r_wptr + ADDR_W'(w_wr);
      r_rptr  <= w_rptr_nxt;
      r_level <= w_level_nxt;
      r_rd_dr <= (w_level_nxt != '0);
      if (w_level_nxt != '0) r_rd_data <= w_bypass ? w_pair : r_mem[w_rptr_nxt];
    end
  end
  // sticky status; a same-cycle event beats clr_status
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_overflow   <= 1'b0;
      r_misalign   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_overflow   <= w_drop | (r_overflow & ~clr_status);
      r_misalign   <= w_misalign_evt | (r_misalign & ~clr_status);
      r_drop_count <= w_drop ? (clr_status ? 16'd1 : (r_drop_count == 16'hFFFF ? r_drop_count : r_drop_count + 16'd1))
                             : (clr_status ? 16'd0 : r_drop_count);
    end
  end
  assign rd_data    = r_rd_data;
  assign rd_dr      = r_rd_dr;
  assign level      = r_level;
  assign overflow   = r_overflow;
  assign misalign   = r_misalign;
  assign drop_count = r_drop_count;
endmodule
